// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the M-stage data-memory controller
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ, WAIT, DONE} dmem_state_t;
  localparam int DMEM_TIMEOUT_DEFAULT = 64;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
endpackage

// File: rtl/timeout_counter.sv
// timeout_counter: counts REQ/WAIT cycles of one access and flags the last permitted cycle
module timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: runs one req/gnt/rvalid access per M-stage load/store and
// holds the pipeline with StallM until it completes or times out
module dmem_stall_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [3:0]        WriteStrbM,
  output logic              StallM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              MemErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  dmem_state_t state_q, state_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, mem_err_q, mem_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [3:0] mem_wstrb_q, mem_wstrb_d;
  logic access, busy, done_hs, timeout, tc;

  assign access  = MemReadM | MemWriteM;
  assign busy    = state_q == REQ || state_q == WAIT;
  // rvalid only counts once the request has been granted
  assign done_hs = mem_rvalid && (state_q == WAIT || (state_q == REQ && mem_gnt));
  assign timeout = busy && tc && !done_hs;

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE && access),
    .en    (busy),
    .tc    (tc)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    mem_err_d   = mem_err_q;
    case (state_q)
      IDLE: if (access) begin
        state_d     = REQ;
        mem_req_d   = 1'b1;
        mem_we_d    = MemWriteM;
        mem_addr_d  = ALUResultM & ~ADDR_W'(3);
        mem_wdata_d = WriteDataM;
        mem_wstrb_d = MemWriteM ? WriteStrbM : 4'h0;
      end
      REQ, WAIT: if (done_hs) begin
        state_d   = DONE;
        mem_req_d = 1'b0;
        rdata_d   = mem_we_q ? rdata_q : mem_rdata;
      end else if (timeout) begin
        state_d   = DONE;
        mem_req_d = 1'b0;
        rdata_d   = '0;
        mem_err_d = 1'b1;
      end else if (state_q == REQ && mem_gnt) begin
        state_d   = WAIT;
        mem_req_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rdata_q     <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      mem_err_q   <= mem_err_d;
    end

  assign StallM    = (state_q == IDLE && access) || busy;
  assign ReadDataM = rdata_q;
  assign MemErr    = mem_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb_dmem_stall_ctrl: random load/store traffic against a latency-programmable memory,
// expected per-access results from a cycle-count model, checked by a monitor on each DONE
module tb_dmem_stall_ctrl;
  import dmem_pkg::*;
  localparam int T = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic [3:0]  WriteStrbM = '0;
  logic        StallM, MemErr, mem_req, mem_we;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  dmem_stall_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WriteStrbM(WriteStrbM),
    .StallM(StallM), .ReadDataM(ReadDataM), .MemErr(MemErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we, err;
    logic [3:0]  strb;
    int          stall, reqs;
  } exp_t;
  typedef struct {
    int          g, r;
    logic [31:0] d;
  } rsp_t;

  exp_t        sb[$];
  rsp_t        rq[$];
  int          total = 0, passed = 0, phase = 0;
  bit          spur = 1'b0;
  logic        model_err = 1'b0;
  logic [31:0] model_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // reference model: g stalled REQ cycles before the grant, r cycles from grant to rvalid
  task automatic expect_push(input bit we, input logic [31:0] addr, wd, input logic [3:0] strb,
                             input int g, r, input logic [31:0] d);
    exp_t e;
    int need;
    need = g + 1 + r;
    e.addr = addr & 32'hFFFF_FFFC;
    e.we = we;
    e.wdata = wd;
    e.strb = we ? strb : 4'h0;
    e.reqs = (g + 1 < T) ? g + 1 : T;
    e.stall = 1 + ((need < T) ? need : T);
    if (need > T) begin
      model_err = 1'b1;
      model_rd = '0;
    end else if (!we) model_rd = d;
    e.err = model_err;
    e.rdata = model_rd;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((phase != 0 || rq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("memory_idle_bound", 0, 1);
    if (n > 0) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input bit we, input logic [31:0] addr, wd, input logic [3:0] strb,
                       input int g, r, input logic [31:0] d);
    rsp_t s;
    s.g = g;
    s.r = r;
    s.d = d;
    rq.push_back(s);
    MemReadM = !we;
    MemWriteM = we;
    ALUResultM = addr;
    WriteDataM = wd;
    WriteStrbM = strb;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (StallM && n < 200);
    if (StallM) check("stall_release_bound", 1, 0);
    @(posedge clk);
    #2;
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, wd, input logic [3:0] strb,
                       input int g, r, input logic [31:0] d);
    wait_idle();
    expect_push(we, addr, wd, strb, g, r, d);
    drive(we, addr, wd, strb, g, r, d);
    wait_done();
  endtask

  // behavioural backing memory
  initial begin
    rsp_t cur;
    int k = 0;
    cur.g = 0;
    cur.r = 0;
    cur.d = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) phase = 0;
      else if (phase == 0 && mem_req && rq.size() != 0) begin
        cur = rq.pop_front();
        phase = 1;
        k = 0;
      end
      if (phase == 1) begin
        if (!mem_req) phase = 0;
        else if (k == cur.g) begin
          mem_gnt = 1'b1;
          if (cur.r == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = cur.d;
            phase = 0;
          end else begin
            phase = 2;
            k = 0;
          end
        end else k++;
      end else if (phase == 2) begin
        k++;
        if (k == cur.r) begin
          mem_rvalid = 1'b1;
          mem_rdata = cur.d;
          phase = 0;
        end
      end else if (spur) begin
        mem_rvalid = 1'b1;
        mem_rdata = $urandom;
        spur = 1'b0;
      end
    end
  end

  // monitor: measures each access and compares at its DONE cycle
  initial begin
    int cnt = 0, reqs = 0;
    bit seen = 1'b0;
    logic [31:0] a = '0, wd = '0;
    logic w = 1'b0;
    logic [3:0] s = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        reqs = 0;
        seen = 1'b0;
      end else if (MemReadM | MemWriteM) begin
        if (mem_req && !seen) begin
          seen = 1'b1;
          a = mem_addr;
          w = mem_we;
          s = mem_wstrb;
          wd = mem_wdata;
        end
        if (mem_req) reqs++;
        if (StallM) cnt++;
        else begin
          if (sb.size() == 0) check("unexpected_done", 1, 0);
          else begin
            e = sb.pop_front();
            check("stall_cycles", cnt, e.stall);
            check("req_cycles", reqs, e.reqs);
            check("mem_addr", a, e.addr);
            check("mem_we", {31'b0, w}, {31'b0, e.we});
            check("mem_wstrb", {28'b0, s}, {28'b0, e.strb});
            if (e.we) check("mem_wdata", wd, e.wdata);
            check("ReadDataM", ReadDataM, e.rdata);
            check("MemErr", {31'b0, MemErr}, {31'b0, e.err});
          end
          cnt = 0;
          reqs = 0;
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] d2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_StallM", {31'b0, StallM}, 0);
    check("rst_mem_req", {31'b0, mem_req}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", {28'b0, mem_wstrb}, 0);
    check("rst_ReadDataM", ReadDataM, 0);
    check("rst_MemErr", {31'b0, MemErr}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    issue(1'b0, 32'h0000_1006, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF);
    issue(1'b1, 32'h0000_2008, 32'h0000_A5C3, 4'b0011, 3, 2, 32'h1234_5678);
    issue(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, 1, 32'h1111_2222);
    issue(1'b0, 32'h0000_3004, 32'h0, 4'h0, 0, 2, 32'h3333_4444);

    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_StallM", {31'b0, StallM}, 0);
      check("spur_mem_req", {31'b0, mem_req}, 0);
      check("spur_ReadDataM", ReadDataM, model_rd);
    end
    @(posedge clk);
    #2;

    for (int i = 0; i < 60; i++) begin
      issue($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(1, 15)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      #0;
    end
    @(posedge clk);
    #2;

    // asynchronous reset in the middle of a WAIT, then the held load reissues
    wait_idle();
    drive(1'b0, 32'h0000_4004, 32'h0, 4'h0, 0, 5, 32'hBAD0_BAD0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("amid_mem_req", {31'b0, mem_req}, 0);
    check("amid_mem_addr", mem_addr, 0);
    check("amid_ReadDataM", ReadDataM, 0);
    check("amid_MemErr", {31'b0, MemErr}, 0);
    check("amid_StallM", {31'b0, StallM}, 1);
    model_err = 1'b0;
    model_rd = '0;
    @(posedge clk);
    #2;
    d2 = 32'hC0DE_0042;
    expect_push(1'b0, 32'h0000_4004, 32'h0, 4'h0, 1, 1, d2);
    rq.push_back('{g: 1, r: 1, d: d2});
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_done();

    issue(1'b0, 32'h0000_5000, 32'h0, 4'h0, 20, 0, 32'h5555_5555);
    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(1, 15)),
            $urandom_range(0, 9), $urandom_range(0, 4), $urandom);
    end
    wait_idle();
    repeat (4) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
